// File: rtl/uart_tx_fifo.sv
// Buffered asynchronous-serial transmitter: a small circular FIFO feeding a
// start/data/parity/stop serialiser whose line output comes straight from a flop.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_BITS-1:0]            s_data,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH)+1-1:0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic          ODD_PARITY  = (PARITY == 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign s_ready    = (count_q < CW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // ---------------------------------------------------------- serialiser
  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 last_tick, load_frame;

  assign last_tick = (baud_q == '0);

  // txd_d is the line level for the cycle after the edge, so every branch
  // that changes bit also chooses the level of the bit being entered.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    load_frame = 1'b0;

    if (state_q != IDLE && !last_tick) baud_d = baud_q - 1'b1;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) load_frame = 1'b1;
      end
      START: begin
        if (last_tick) begin
          state_d = DATA;
          bit_d   = '0;
          baud_d  = BAUD_RELOAD;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (last_tick) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[1];
          end
        end
      end
      PAR: begin
        if (last_tick) begin
          state_d = STOP;
          bit_d   = '0;
          baud_d  = BAUD_RELOAD;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (last_tick) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              load_frame = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            baud_d = BAUD_RELOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (load_frame) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = (^head) ^ ODD_PARITY;
      state_d = START;
      baud_d  = BAUD_RELOAD;
      bit_d   = '0;
      txd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Drives three differently configured transmitters from one producer and
// compares every cycle against a queue-based model of the expected line waveform.
module tb_uart_tx_fifo;

  localparam int C = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_valid;
  logic [8:0] s_data;

  logic       txd0, txd1, txd2;
  logic       busy0, busy1, busy2;
  logic       rdy0, rdy1, rdy2;
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;

  // 8N1, depth 4
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data[7:0]),
    .txd(txd0), .busy(busy0), .fifo_count(cnt0));

  // 7E2, depth 4
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data[6:0]),
    .txd(txd1), .busy(busy1), .fifo_count(cnt1));

  // 8O1, depth 2
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy2), .s_data(s_data[7:0]),
    .txd(txd2), .busy(busy2), .fifo_count(cnt2));

  int DB  [N] = '{8, 7, 8};
  int PAR [N] = '{0, 2, 1};
  int SB  [N] = '{1, 2, 1};
  int DEP [N] = '{4, 4, 2};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dut_acc0 = 0;

  logic [8:0] pend [N][$];
  bit         wave [N][$];
  bit         exp_txd  [N];
  bit         in_frame [N];
  bit         acc      [N];

  function automatic void gen_frame(int i, logic [8:0] w);
    bit bits[$];
    bit p;
    bits.push_back(1'b0);
    for (int k = 0; k < DB[i]; k++) bits.push_back(w[k]);
    if (PAR[i] != 0) begin
      p = ($countones(w) % 2) == 1;
      if (PAR[i] == 1) p = !p;
      bits.push_back(p);
    end
    for (int k = 0; k < SB[i]; k++) bits.push_back(1'b1);
    foreach (bits[k])
      for (int r = 0; r < C; r++) wave[i].push_back(bits[k]);
  endfunction

  function automatic void model_edge(bit r, bit v, logic [8:0] d);
    for (int i = 0; i < N; i++) begin
      acc[i] = 1'b0;
      if (r) begin
        pend[i].delete();
        wave[i].delete();
        exp_txd[i]  = 1'b1;
        in_frame[i] = 1'b0;
      end else begin
        int pre = pend[i].size();
        logic [8:0] m = 9'((1 << DB[i]) - 1);
        acc[i] = v && (pre < DEP[i]);
        if (wave[i].size() == 0 && pre > 0) gen_frame(i, pend[i].pop_front());
        if (acc[i]) pend[i].push_back(d & m);
        if (wave[i].size() > 0) begin
          exp_txd[i]  = wave[i].pop_front();
          in_frame[i] = 1'b1;
        end else begin
          exp_txd[i]  = 1'b1;
          in_frame[i] = 1'b0;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_all();
    logic t, b, r;
    logic [2:0] c;
    for (int i = 0; i < N; i++) begin
      case (i)
        0:       {t, b, r, c} = {txd0, busy0, rdy0, cnt0};
        1:       {t, b, r, c} = {txd1, busy1, rdy1, cnt1};
        default: {t, b, r, c} = {txd2, busy2, rdy2, 1'b0, cnt2};
      endcase
      check($sformatf("txd%0d", i),   32'(t), 32'(exp_txd[i]));
      check($sformatf("busy%0d", i),  32'(b), 32'(in_frame[i] || pend[i].size() != 0));
      check($sformatf("count%0d", i), 32'(c), 32'(pend[i].size()));
      check($sformatf("ready%0d", i), 32'(r), 32'(pend[i].size() < DEP[i]));
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [8:0] d);
    rst = r; s_valid = v; s_data = d;
    if (v && !r && rdy0) dut_acc0++;
    @(posedge clk);
    model_edge(r, v, d);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 9'h000);
  endtask

  initial begin
    int w;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;

    // reset with a word presented: it must be dropped
    repeat (3) cycle(1'b1, 1'b1, 9'h033);
    check("reset_txd", 32'(txd0), 32'd1);
    check("reset_ready", 32'(rdy0), 32'd1);
    check("reset_count", 32'(cnt0), 32'd0);
    idle(2);

    // single 0xA5 frame: start after acceptance+1, busy for 40 cycles
    cycle(1'b0, 1'b1, 9'h0A5);
    check("a5_count_after_push", 32'(cnt0), 32'd1);
    idle(1);
    check("a5_start_bit", 32'(txd0), 32'd0);
    check("a5_popped", 32'(cnt0), 32'd0);
    idle(39);
    check("a5_busy_last", 32'(busy0), 32'd1);
    idle(1);
    check("a5_busy_fall", 32'(busy0), 32'd0);
    idle(20);

    // parity with three ones
    cycle(1'b0, 1'b1, 9'h007);
    idle(60);

    // producer holds valid with 0x01..0x06 on the 8N1 instance
    dut_acc0 = 0;
    w = 1;
    for (int n = 0; n < 200 && w <= 6; n++) begin
      cycle(1'b0, 1'b1, 9'(w));
      if (acc[0]) w++;
      if (n == 30) begin
        check("hold_acc_before_frame_end", 32'(dut_acc0), 32'd5);
        check("hold_full_count", 32'(cnt0), 32'd4);
        check("hold_not_ready", 32'(rdy0), 32'd0);
      end
    end
    check("hold_total_acc", 32'(dut_acc0), 32'd6);
    idle(300);

    // offer a word while full: not stored
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 9'(8'h10 + k));
    check("full_count", 32'(cnt0), 32'd4);
    check("full_not_ready", 32'(rdy0), 32'd0);
    cycle(1'b0, 1'b1, 9'h0EE);
    check("full_drop_count", 32'(cnt0), 32'd4);
    idle(250);

    // reset in the data bits of a frame with three words queued
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 9'(8'h3C + k));
    idle(10);
    check("midrst_queued", 32'(cnt0), 32'd3);
    cycle(1'b1, 1'b0, 9'h000);
    check("midrst_txd", 32'(txd0), 32'd1);
    check("midrst_count", 32'(cnt0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    idle(100);

    // random traffic
    repeat (600) cycle(1'b0, $urandom_range(0, 2) == 0, 9'($urandom));
    idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
